// File: rtl/add_sub64_pipe.sv
// Two-stage pipelined 64-bit adder/subtractor with valid/ready on both sides.
// Low half is summed in stage 1, the bit-32 carry is registered, and the high half is summed in stage 2.
module add_sub64_pipe #(
  parameter int N = 64,
  parameter int M = N / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  // Occupancy, carried only by the two valid bits:
  //   state | meaning
  //   EMPTY | v1=0 v2=0, nothing in flight
  //   ONE   | exactly one of v1/v2 set
  //   FULL  | v1=1 v2=1, stalls intake while out_ready=0
  localparam int H = N - M;

  logic         v1;
  logic         v2;
  logic         accept;
  logic         adv2;

  logic [N-1:0] bx;
  logic         cx;
  logic [M:0]   lo_sum;

  logic [M-1:0] s_lo_q;
  logic         c32_q;
  logic [H-1:0] a_hi_q;
  logic [H-1:0] bx_hi_q;

  logic [H:0]   hi_sum;
  logic [N-1:0] s_nxt;
  logic         c_into_msb;

  // Subtract is folded into the single adder form a + ~b + ~cin.
  assign bx     = op ? ~b : b;
  assign cx     = op ? ~cin : cin;
  assign lo_sum = {1'b0, a[M-1:0]} + {1'b0, bx[M-1:0]} + {{M{1'b0}}, cx};

  assign hi_sum = {1'b0, a_hi_q} + {1'b0, bx_hi_q} + {{H{1'b0}}, c32_q};
  assign s_nxt  = {hi_sum[H-1:0], s_lo_q};
  // Carry into the sign bit recovered from the sum bit and its two operand bits.
  assign c_into_msb = s_nxt[N-1] ^ a_hi_q[H-1] ^ bx_hi_q[H-1];

  assign out_valid = v2;
  assign adv2      = v1 & (~v2 | out_ready);
  assign in_ready  = ~rst & (~v1 | adv2);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (accept) begin
      v1 <= 1'b1;
    end else if (adv2) begin
      v1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2 <= 1'b1;
    end else if (out_ready) begin
      v2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_lo_q  <= '0;
      c32_q   <= 1'b0;
      a_hi_q  <= '0;
      bx_hi_q <= '0;
    end else if (accept) begin
      s_lo_q  <= lo_sum[M-1:0];
      c32_q   <= lo_sum[M];
      a_hi_q  <= a[N-1:M];
      bx_hi_q <= bx[N-1:M];
    end
  end

  // Output registers only move on adv2, which gives the hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv2) begin
      s    <= s_nxt;
      cout <= hi_sum[H];
      ovf  <= c_into_msb ^ hi_sum[H];
      zero <= (s_nxt == '0);
    end
  end

endmodule

// File: tb/tb_add_sub64_pipe.sv
// Randomized and directed bench for add_sub64_pipe, scored against an integer-arithmetic model.
// Inputs change 1 time unit after the rising edge; handshakes are observed on the falling edge.
module tb_add_sub64_pipe;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic        cin;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_out = 0;
  res_t exp_q[$];

  add_sub64_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cin(cin), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned 65-bit for the carry, signed 66-bit for overflow.
  function automatic res_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic mop, input logic mcin);
    res_t r;
    logic [64:0]        w;
    logic signed [65:0] sr;
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] sc;
    sa = $signed({{2{ma[63]}}, ma});
    sb = $signed({{2{mb[63]}}, mb});
    sc = $signed({65'b0, mcin});
    if (!mop) begin
      w      = {1'b0, ma} + {1'b0, mb} + {64'b0, mcin};
      sr     = sa + sb + sc;
      r.cout = w[64];
    end else begin
      w      = {1'b0, ma} - {1'b0, mb} - {64'b0, mcin};
      sr     = sa - sb - sc;
      r.cout = ~w[64];
    end
    r.s    = w[63:0];
    r.ovf  = (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
    r.zero = (w[63:0] == 64'b0);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_s", s, e.s);
          chk("sb_cout", {63'b0, cout}, {63'b0, e.cout});
          chk("sb_ovf", {63'b0, ovf}, {63'b0, e.ovf});
          chk("sb_zero", {63'b0, zero}, {63'b0, e.zero});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, op, cin));
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [63:0] da, input logic [63:0] db,
                          input logic dop, input logic dcin, input logic [63:0] es,
                          input logic ec, input logic eo, input logic ez);
    a = da; b = db; op = dop; cin = dcin;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat_early"}, {63'b0, out_valid}, 64'd0);
    tick();
    chk({tag, "_lat_valid"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, {63'b0, cout}, {63'b0, ec});
    chk({tag, "_ovf"}, {63'b0, ovf}, {63'b0, eo});
    chk({tag, "_zero"}, {63'b0, zero}, {63'b0, ez});
    tick();
  endtask

  task automatic rand_beat();
    a   = {$urandom(), $urandom()};
    b   = {$urandom(), $urandom()};
    op  = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string tag);
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    int acc0;
    int out0;
    logic [63:0] s_hold;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    op = 1'b0; cin = 1'b0; a = 64'd5; b = 64'd7;
    tick();
    tick();
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_s", s, 64'd0);
    chk("rst_flags", {61'b0, cout, ovf, zero}, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    tick();

    directed("carry32", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    directed("sub_zero", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0,
             64'd0, 1'b1, 1'b0, 1'b1);
    directed("sub_wrap", 64'd0, 64'd1, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("add_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1,
             64'd0, 1'b1, 1'b0, 1'b1);
    directed("sub_borrow", 64'd10, 64'd3, 1'b1, 1'b1,
             64'd6, 1'b1, 1'b0, 1'b0);

    // Streaming: one accept per cycle, and one result per cycle once the pipe has filled.
    acc0 = n_acc; out0 = n_out;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      #1;
      chk("stream_in_ready", {63'b0, in_ready}, 64'd1);
      if (i >= 2) chk("stream_out_valid", {63'b0, out_valid}, 64'd1);
      tick();
    end
    chk("stream_accepts", 64'(n_acc - acc0), 64'd100);
    drain("stream");
    chk("stream_results", 64'(n_out - out0), 64'd100);

    // Backpressure: third beat waits until out_ready returns.
    acc0 = n_acc;
    out_ready = 1'b0; in_valid = 1'b1;
    rand_beat(); tick();
    rand_beat(); tick();
    rand_beat();
    s_hold = s;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_s_hold", s, s_hold);
      chk("bp_s_first", s, exp_q[0].s);
      tick();
    end
    chk("bp_accepts", 64'(n_acc - acc0), 64'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_third_accepted", 64'(n_acc - acc0), 64'd3);
    drain("bp");

    // Reset with two beats in flight: nothing stale may emerge afterwards.
    out_ready = 1'b0; in_valid = 1'b1;
    rand_beat(); tick();
    rand_beat(); tick();
    chk("mid_full", {63'b0, out_valid}, 64'd1);
    rst = 1'b1;
    rand_beat();
    #1;
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    acc0 = n_acc;
    tick();
    exp_q.delete();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_s", s, 64'd0);
    chk("mid_in_ready", {63'b0, in_ready}, 64'd1);
    chk("mid_no_accept", 64'(n_acc - acc0), 64'd0);
    out0 = n_out;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", {63'b0, out_valid}, 64'd0);
    end
    chk("mid_no_outputs", 64'(n_out - out0), 64'd0);

    // Random traffic with random stalls on both sides.
    for (int i = 0; i < 300; i++) begin
      rand_beat();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/add_sub64_pipe.md
# add_sub64_pipe

Two-stage pipelined 64-bit adder/subtractor with a valid/ready handshake on both sides. The low 32 bits are computed in stage 1, the carry is registered at the bit-32 boundary, and the high 32 bits are computed in stage 2. It is the sequential, subtract-capable counterpart to the combinational 64-bit carry-lookahead adder. It sits between an operand producer and a result consumer in the datapath, and both sides may stall.

## Interface
- N, 64, operand/result width; the only supported value is 64.
- M, 32, split point (stage-1 width); fixed at N/2.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- op  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in for add; borrow-in for subtract.
- a  in  64  operand A.
- b  in  64  operand B.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- s  out  64  result.
- cout  out  1  raw carry out of bit 63. For subtract this is NOT-borrow.
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.

## Operation
- Arithmetic is a single adder form: s = a + bx + cx (mod 2^64).
  - add: bx = b, cx = cin.
  - subtract: bx = ~b, cx = ~cin, which gives a − b − cin.
- Stage 1 on accept (in_valid & in_ready):
  - Register s_lo = (a[31:0] + bx[31:0] + cx)[31:0] and c32 = carry out of that sum.
  - Register a[63:32] and bx[63:32].
  - Set v1 = 1.
- Stage 2 on advance:
  - Compute hi = a_hi + bx_hi + c32 (33 bits).
  - Register s = {hi[31:0], s_lo}, cout = hi[32], ovf = carry-into-bit-63 XOR cout, zero = (s == 0).
  - Set v2 = 1.
- Flow control:
  - out_valid = v2.
  - adv2 = v1 & (!v2 | out_ready).
  - in_ready = !rst & (!v1 | adv2).
  - This gives full throughput of one beat per cycle, with no bubbles under continuous out_ready.
- Stage registers clear their valid bit when drained and not refilled:
  - v2 clears on (out_ready & !adv2).
  - v1 clears on (adv2 & !accept).
- Data registers load only on their stage's load enable; they hold otherwise.
- Outputs s, cout, ovf, zero are stable while out_valid = 1 and out_ready = 0. This is an AXI-style hold.
- There is no state machine beyond the two valid bits. The effective states are EMPTY (v1=0, v2=0), ONE (exactly one set) and FULL (both set).

## Timing
- Reset (rst high at a clock edge):
  - v1, v2, s, cout, ovf and zero are forced to 0.
  - out_valid = 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst drops.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+1, i.e. it is visible in cycle k+1 and can be consumed at edge k+2.
- Full, with out_ready = 0: in_ready = 0, nothing advances, and all registers hold.
- Full, with out_ready = 1: in the same edge, stage 2 hands off, stage 1 moves to stage 2, and a new beat may enter stage 1.
- Empty: out_valid = 0. The values on s, cout, ovf and zero are don't-care for the consumer, but they hold their last values.
- Reset mid-operation: in-flight beats are discarded with no output pulse. Any beat presented in the same cycle as rst is not accepted.
- Wrap-around: the result is modulo 2^64. cout and ovf report the wrap; there is no saturation.
- in_ready depends combinationally on out_ready. out_valid and all data outputs are registered.

## Test plan
- Add with cross-boundary carry: a=0x0000_0000_FFFF_FFFF, b=1, op=0, cin=0 -> s=0x0000_0001_0000_0000, cout=0, ovf=0, zero=0. out_valid rises 1 cycle after accept.
- Subtract to zero and wrap:
  - a=b=0x1234_5678_9ABC_DEF0, op=1, cin=0 -> s=0, zero=1, cout=1.
  - a=0, b=1, op=1 -> s=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0.
- Signed overflow:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=0 -> s=0x8000_0000_0000_0000, ovf=1, cout=0.
  - a=0x8000_0000_0000_0000, b=1, op=1 -> s=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Back-to-back streaming: 100 random beats with in_valid and out_ready held at 1 -> exactly one result per cycle, in order, all matching a reference model.
- Backpressure:
  - Hold out_ready=0 while sending 3 beats -> exactly 2 are accepted, then in_ready=0, and s holds the first result stable.
  - Release out_ready -> results drain in order and the third beat is accepted on that same edge.
- Reset mid-flight: with 2 beats in flight, assert rst for 1 cycle -> out_valid=0 and s=0 after the edge, no stale beat ever appears, and in_ready=1 the cycle after rst drops.
